// File: rtl/pipe_pkg.sv
// Shared widths and the writeback-stage payload layout for the pipe_wb_reg slice.
package pipe_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int RAW_DEFAULT  = 5;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] dmout;
        logic [XLEN_DEFAULT-1:0] aluout;
        logic [RAW_DEFAULT-1:0]  writeregister;
        logic                    memtoreg;
        logic                    regwrite;
    } wb_payload_t;

    // Flattened payload width for arbitrary XLEN/RAW; field order matches wb_payload_t.
    function automatic int payload_width(input int xlen, input int raw);
        return 2 * xlen + raw + 2;
    endfunction

endpackage

// File: rtl/pipe_wb_slot.sv
// One writeback pipeline slot: valid bit plus flattened payload, with clear and hold.
module pipe_wb_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         valid,
    output logic [W-1:0] data
);

    // Clear only drops the valid bit; the payload is left as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= in_valid;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_wb_reg.sv
// Cascaded MEM/WB register (DEPTH slots) with writeback select, forwarding lookup
// and a retired-instruction counter.
module pipe_wb_reg
    import pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int RAW   = RAW_DEFAULT,
    parameter int DEPTH = 1            // 1..4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] dmout,
    input  logic [XLEN-1:0] aluout,
    input  logic [RAW-1:0]  writeregister,
    input  logic            memtoreg,
    input  logic            regwrite,
    input  logic            stall,
    input  logic            flush,
    input  logic [RAW-1:0]  fwd_rs,
    output logic            out_valid,
    output logic [XLEN-1:0] dmout_out,
    output logic [XLEN-1:0] aluout_out,
    output logic [RAW-1:0]  writeregister_out,
    output logic            memtoreg_out,
    output logic            regwrite_out,
    output logic [XLEN-1:0] wb_data,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_data,
    output logic [31:0]     retire_cnt
);

    localparam int PW = payload_width(XLEN, RAW);

    logic [DEPTH-1:0]          vld_pipe;
    logic [DEPTH-1:0][PW-1:0]  pl_pipe;
    logic [DEPTH-1:0]          slot_vin;
    logic [DEPTH-1:0][PW-1:0]  slot_din;

    logic [DEPTH-1:0][XLEN-1:0] st_dm, st_alu, st_sel;
    logic [DEPTH-1:0][RAW-1:0]  st_rd;
    logic [DEPTH-1:0]           st_m2r, st_rw, st_match;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign slot_vin[g] = in_valid;
                assign slot_din[g] = {dmout, aluout, writeregister, memtoreg, regwrite};
            end else begin : g_chain
                assign slot_vin[g] = vld_pipe[g-1];
                assign slot_din[g] = pl_pipe[g-1];
            end

            pipe_wb_slot #(.W(PW)) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .hold     (stall),
                .clear    (flush),
                .in_valid (slot_vin[g]),
                .in_data  (slot_din[g]),
                .valid    (vld_pipe[g]),
                .data     (pl_pipe[g])
            );

            assign st_rw[g]    = pl_pipe[g][0];
            assign st_m2r[g]   = pl_pipe[g][1];
            assign st_rd[g]    = pl_pipe[g][RAW+1:2];
            assign st_alu[g]   = pl_pipe[g][XLEN+RAW+1:RAW+2];
            assign st_dm[g]    = pl_pipe[g][2*XLEN+RAW+1:XLEN+RAW+2];
            assign st_sel[g]   = st_m2r[g] ? st_dm[g] : st_alu[g];
            assign st_match[g] = vld_pipe[g] && st_rw[g] && (st_rd[g] != '0)
                                 && (st_rd[g] == fwd_rs);
        end
    endgenerate

    assign out_valid         = vld_pipe[DEPTH-1];
    assign dmout_out         = st_dm[DEPTH-1];
    assign aluout_out        = st_alu[DEPTH-1];
    assign writeregister_out = st_rd[DEPTH-1];
    assign memtoreg_out      = st_m2r[DEPTH-1];
    assign regwrite_out      = st_rw[DEPTH-1] && out_valid && (st_rd[DEPTH-1] != '0);
    assign wb_data           = st_sel[DEPTH-1];

    // Scan oldest to youngest so the lowest-index (youngest) match is written last and wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (st_match[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = st_sel[k];
            end
        end
    end

    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_valid && !stall && !flush) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Bench for pipe_wb_reg at DEPTH=1 and DEPTH=3 against a stage-list reference model.
module tb_pipe_wb_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] dmout = '0, aluout = '0;
    logic [4:0]  writeregister = '0, fwd_rs = '0;
    logic        memtoreg = 1'b0, regwrite = 1'b0, stall = 1'b0, flush = 1'b0;

    logic        out_valid_1, memtoreg_out_1, regwrite_out_1, fwd_hit_1;
    logic [63:0] dmout_out_1, aluout_out_1, wb_data_1, fwd_data_1;
    logic [4:0]  writeregister_out_1;
    logic [31:0] retire_cnt_1;
    logic        out_valid_3, memtoreg_out_3, regwrite_out_3, fwd_hit_3;
    logic [63:0] dmout_out_3, aluout_out_3, wb_data_3, fwd_data_3;
    logic [4:0]  writeregister_out_3;
    logic [31:0] retire_cnt_3;

    always #5 clk = ~clk;

    pipe_wb_reg #(.XLEN(64), .RAW(5), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .dmout(dmout), .aluout(aluout),
        .writeregister(writeregister), .memtoreg(memtoreg), .regwrite(regwrite),
        .stall(stall), .flush(flush), .fwd_rs(fwd_rs), .out_valid(out_valid_1),
        .dmout_out(dmout_out_1), .aluout_out(aluout_out_1),
        .writeregister_out(writeregister_out_1), .memtoreg_out(memtoreg_out_1),
        .regwrite_out(regwrite_out_1), .wb_data(wb_data_1), .fwd_hit(fwd_hit_1),
        .fwd_data(fwd_data_1), .retire_cnt(retire_cnt_1));

    pipe_wb_reg #(.XLEN(64), .RAW(5), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .dmout(dmout), .aluout(aluout),
        .writeregister(writeregister), .memtoreg(memtoreg), .regwrite(regwrite),
        .stall(stall), .flush(flush), .fwd_rs(fwd_rs), .out_valid(out_valid_3),
        .dmout_out(dmout_out_3), .aluout_out(aluout_out_3),
        .writeregister_out(writeregister_out_3), .memtoreg_out(memtoreg_out_3),
        .regwrite_out(regwrite_out_3), .wb_data(wb_data_3), .fwd_hit(fwd_hit_3),
        .fwd_data(fwd_data_3), .retire_cnt(retire_cnt_3));

    int errors = 0;
    int checks = 0;

    // Model: index 0 = DEPTH 1 instance, index 1 = DEPTH 3 instance; slot 0 is youngest.
    bit          mv [2][4];
    wb_payload_t mp [2][4];
    logic [31:0] mcnt [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = '0;
            for (int k = 0; k < 4; k++) begin
                mv[i][k] = 1'b0;
                mp[i][k] = '0;
            end
        end
    endtask

    task automatic model_edge();
        wb_payload_t cur;
        cur = '{dmout: dmout, aluout: aluout, writeregister: writeregister,
                memtoreg: memtoreg, regwrite: regwrite};
        for (int i = 0; i < 2; i++) begin
            int d = depth_of(i);
            if (mv[i][d-1] && !stall && !flush) mcnt[i] = mcnt[i] + 32'd1;
            if (flush) begin
                for (int k = 0; k < 4; k++) mv[i][k] = 1'b0;
            end else if (!stall) begin
                for (int k = d - 1; k > 0; k--) begin
                    mv[i][k] = mv[i][k-1];
                    mp[i][k] = mp[i][k-1];
                end
                mv[i][0] = in_valid;
                mp[i][0] = cur;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            int d = depth_of(i);
            bit ev = mv[i][d-1];
            wb_payload_t p = mp[i][d-1];
            logic        e_rw  = p.regwrite && ev && (p.writeregister != 0);
            logic [63:0] e_wb  = p.memtoreg ? p.dmout : p.aluout;
            logic        e_hit = 1'b0;
            logic [63:0] e_fd  = '0;
            string s = $sformatf("%s/d%0d", tag, d);
            for (int k = 0; k < d; k++) begin
                if (!e_hit && mv[i][k] && mp[i][k].regwrite && mp[i][k].writeregister != 0
                    && mp[i][k].writeregister == fwd_rs) begin
                    e_hit = 1'b1;
                    e_fd  = mp[i][k].memtoreg ? mp[i][k].dmout : mp[i][k].aluout;
                end
            end
            if (i == 0) begin
                chk({s, "/out_valid"}, 64'(out_valid_1), 64'(ev));
                chk({s, "/dmout_out"}, dmout_out_1, p.dmout);
                chk({s, "/aluout_out"}, aluout_out_1, p.aluout);
                chk({s, "/rd_out"}, 64'(writeregister_out_1), 64'(p.writeregister));
                chk({s, "/memtoreg_out"}, 64'(memtoreg_out_1), 64'(p.memtoreg));
                chk({s, "/regwrite_out"}, 64'(regwrite_out_1), 64'(e_rw));
                chk({s, "/wb_data"}, wb_data_1, e_wb);
                chk({s, "/fwd_hit"}, 64'(fwd_hit_1), 64'(e_hit));
                chk({s, "/fwd_data"}, fwd_data_1, e_fd);
                chk({s, "/retire_cnt"}, 64'(retire_cnt_1), 64'(mcnt[i]));
            end else begin
                chk({s, "/out_valid"}, 64'(out_valid_3), 64'(ev));
                chk({s, "/dmout_out"}, dmout_out_3, p.dmout);
                chk({s, "/aluout_out"}, aluout_out_3, p.aluout);
                chk({s, "/rd_out"}, 64'(writeregister_out_3), 64'(p.writeregister));
                chk({s, "/memtoreg_out"}, 64'(memtoreg_out_3), 64'(p.memtoreg));
                chk({s, "/regwrite_out"}, 64'(regwrite_out_3), 64'(e_rw));
                chk({s, "/wb_data"}, wb_data_3, e_wb);
                chk({s, "/fwd_hit"}, 64'(fwd_hit_3), 64'(e_hit));
                chk({s, "/fwd_data"}, fwd_data_3, e_fd);
                chk({s, "/retire_cnt"}, 64'(retire_cnt_3), 64'(mcnt[i]));
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [63:0] alu,
                         input logic [63:0] dm, input logic m2r, input logic rw);
        in_valid = v; writeregister = rd; aluout = alu; dmout = dm;
        memtoreg = m2r; regwrite = rw;
    endtask

    task automatic rand_inputs();
        drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        fwd_rs = 5'($urandom_range(0, 7));
        stall  = $urandom_range(0, 5) == 0;
        flush  = $urandom_range(0, 9) == 0;
    endtask

    initial begin
        model_reset();
        // Inputs toggling during reset must not load anything.
        drive(1'b1, 5'd3, 64'h55, 64'h66, 1'b0, 1'b1);
        #22;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-stage basic writeback.
        drive(1'b1, 5'd3, 64'h11, 64'hDEAD, 1'b0, 1'b1);
        fwd_rs = 5'd0;
        step("basic");
        chk("basic/out_valid", 64'(out_valid_1), 64'd1);
        chk("basic/regwrite_out", 64'(regwrite_out_1), 64'd1);
        chk("basic/wb_data", wb_data_1, 64'h11);
        drive(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
        step("basic2");
        chk("basic/retire_cnt", 64'(retire_cnt_1), 64'd1);

        // rd=0 is never written back.
        drive(1'b1, 5'd0, 64'h77, 64'h0, 1'b0, 1'b1);
        step("rd0");
        chk("rd0/regwrite_out", 64'(regwrite_out_1), 64'd0);

        // Forwarding: youngest match wins.
        fwd_rs = 5'd5;
        drive(1'b1, 5'd5, 64'h0, 64'hB, 1'b1, 1'b1);
        step("fwd_a");
        drive(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
        step("fwd_b");
        drive(1'b1, 5'd5, 64'hA, 64'h0, 1'b0, 1'b1);
        step("fwd_c");
        chk("fwd/hit", 64'(fwd_hit_3), 64'd1);
        chk("fwd/data", fwd_data_3, 64'hA);
        drive(1'b1, 5'd0, 64'h0, 64'hB, 1'b1, 1'b1);
        step("fwd0_a");
        drive(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
        step("fwd0_b");
        drive(1'b1, 5'd0, 64'hA, 64'h0, 1'b0, 1'b1);
        step("fwd0_c");
        chk("fwd0/hit", 64'(fwd_hit_3), 64'd0);
        chk("fwd0/data", fwd_data_3, 64'd0);

        // Stall for two cycles mid-stream.
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 5'(n + 1), 64'(100 + n), 64'(200 + n), 1'(n & 1), 1'b1);
            step("fill");
        end
        stall = 1'b1;
        drive(1'b1, 5'd9, 64'h999, 64'h999, 1'b0, 1'b1);
        step("stall1");
        step("stall2");
        stall = 1'b0;
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
            step("drain");
        end

        // Flush with all three stages valid, plus an incoming instruction.
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'(n + 4), 64'(300 + n), 64'h0, 1'b0, 1'b1);
            step("fill2");
        end
        flush = 1'b1;
        drive(1'b1, 5'd7, 64'h333, 64'h0, 1'b0, 1'b1);
        step("flush");
        flush = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            chk("flush/out_valid", 64'(out_valid_3), 64'd0);
            chk("flush/regwrite_out", 64'(regwrite_out_3), 64'd0);
            step("post_flush");
        end

        // Counter wrap.
        drive(1'b1, 5'd2, 64'h42, 64'h0, 1'b0, 1'b1);
        step("wrap_fill");
        force dut1.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut1.cnt_q;
        mcnt[0] = 32'hFFFF_FFFF;
        step("wrap");
        chk("wrap/retire_cnt", 64'(retire_cnt_1), 64'd0);

        // Async reset pulse between edges while stalled.
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 5'(n + 1), 64'(500 + n), 64'(600 + n), 1'b0, 1'b1);
            step("prefill");
        end
        fwd_rs = 5'd1;
        @(negedge clk);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_pulse");
        chk("rst_pulse/out_valid", 64'(out_valid_3), 64'd0);
        chk("rst_pulse/wb_data", wb_data_3, 64'd0);
        chk("rst_pulse/retire_cnt", 64'(retire_cnt_3), 64'd0);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        drive(1'b1, 5'd6, 64'h66, 64'h0, 1'b0, 1'b1);
        step("resume");
        chk("resume/out_valid", 64'(out_valid_1), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
